// File: rtl/counter_pkg.sv
// Shared types and encodings for the multi-mode counter and its prescaler.
package counter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } state_e;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: tick_o is high on every (div_i+1)-th enabled cycle.
module counter_prescaler #(
   parameter int unsigned PRE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic [PRE_WIDTH-1:0] div_i,
   output logic                 tick_o
);

   localparam logic [PRE_WIDTH-1:0] PreOne = PRE_WIDTH'(1);

   logic [PRE_WIDTH-1:0] r_cnt_q;
   logic [PRE_WIDTH-1:0] w_cnt_d;

   assign tick_o = en_i && (r_cnt_q == div_i);

   always_comb begin
      w_cnt_d = r_cnt_q;
      if (clear_i) begin
         w_cnt_d = '0;
      end else if (en_i) begin
         w_cnt_d = tick_o ? '0 : r_cnt_q + PreOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_q <= '0;
      end else begin
         r_cnt_q <= w_cnt_d;
      end
   end

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down, one-shot/auto-reload counter with prescaler, pause, abort and a
// saturating completed-period count.
module multi_mode_counter
   import counter_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 7,
   parameter int unsigned PRE_WIDTH = 4,
   parameter int unsigned PERIOD_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] cnt_val_i,
   input  logic                 mode_i,
   input  logic                 dir_i,
   input  logic [PRE_WIDTH-1:0] prescale_i,
   input  logic                 pause_i,
   input  logic                 abort_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [PERIOD_W-1:0]  period_cnt_o
);

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic [PERIOD_W-1:0]  PerOne = PERIOD_W'(1);
   localparam logic [PERIOD_W-1:0]  PerMax = {PERIOD_W{1'b1}};

   state_e               r_state_q;
   state_e               w_state_d;
   logic [CNT_WIDTH-1:0] r_cnt_q;
   logic [CNT_WIDTH-1:0] w_cnt_d;
   logic [PERIOD_W-1:0]  r_period_q;
   logic [PERIOD_W-1:0]  w_period_d;
   logic                 r_done_q;
   logic                 w_done_d;

   logic [CNT_WIDTH-1:0] r_val_q;
   logic [PRE_WIDTH-1:0] r_pre_q;
   logic                 r_mode_q;
   logic                 r_dir_q;

   logic                 w_start;
   logic                 w_active;
   logic                 w_cnt_en;
   logic                 w_pre_clear;
   logic                 w_tick;
   logic                 w_terminal;
   logic [CNT_WIDTH-1:0] w_reload_val;

   assign w_start      = (r_state_q == StIdle) && start_i;
   assign w_active     = (r_state_q == StRun) || (r_state_q == StPause);
   // Leaving PAUSE with pause_i low counts on that same edge, so a pause of
   // N sampled cycles delays the run by exactly N cycles.
   assign w_cnt_en     = w_active && !abort_i && !pause_i;
   assign w_pre_clear  = w_start || (w_active && abort_i);
   assign w_terminal   = (r_dir_q == DIR_DOWN) ? (r_cnt_q == '0) : (r_cnt_q == r_val_q);
   assign w_reload_val = (r_dir_q == DIR_DOWN) ? r_val_q : '0;

   counter_prescaler #(
      .PRE_WIDTH (PRE_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (w_pre_clear),
      .en_i    (w_cnt_en),
      .div_i   (r_pre_q),
      .tick_o  (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val_q  <= '0;
         r_pre_q  <= '0;
         r_mode_q <= MODE_ONESHOT;
         r_dir_q  <= DIR_UP;
      end else if (w_start) begin
         r_val_q  <= cnt_val_i;
         r_pre_q  <= prescale_i;
         r_mode_q <= mode_i;
         r_dir_q  <= dir_i;
      end
   end

   always_comb begin
      w_state_d  = r_state_q;
      w_cnt_d    = r_cnt_q;
      w_period_d = r_period_q;
      w_done_d   = 1'b0;
      unique case (r_state_q)
         StIdle: begin
            if (start_i) begin
               w_state_d  = StRun;
               w_cnt_d    = (dir_i == DIR_DOWN) ? cnt_val_i : '0;
               w_period_d = '0;
            end
         end
         StRun, StPause: begin
            if (abort_i) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end else if (pause_i) begin
               w_state_d = StPause;
            end else begin
               w_state_d = StRun;
               if (w_tick) begin
                  if (w_terminal) begin
                     w_done_d = 1'b1;
                     if (r_period_q != PerMax) begin
                        w_period_d = r_period_q + PerOne;
                     end
                     if (r_mode_q == MODE_ONESHOT) begin
                        w_state_d = StDone;
                     end else begin
                        w_cnt_d = w_reload_val;
                     end
                  end else if (r_dir_q == DIR_DOWN) begin
                     w_cnt_d = r_cnt_q - CntOne;
                  end else begin
                     w_cnt_d = r_cnt_q + CntOne;
                  end
               end
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q  <= StIdle;
         r_cnt_q    <= '0;
         r_period_q <= '0;
         r_done_q   <= 1'b0;
      end else begin
         r_state_q  <= w_state_d;
         r_cnt_q    <= w_cnt_d;
         r_period_q <= w_period_d;
         r_done_q   <= w_done_d;
      end
   end

   assign cnt_o        = r_cnt_q;
   assign busy_o       = (r_state_q != StIdle);
   assign done_o       = r_done_q;
   assign period_cnt_o = r_period_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Self-checking bench: directed table, corner-case sequences and random
// stimulus against a tick-arithmetic reference model.
module tb_multi_mode_counter;

   logic       clk;
   logic       rst_n;
   logic       s_start;
   logic [6:0] s_val;
   logic       s_mode;
   logic       s_dir;
   logic [3:0] s_pre;
   logic       s_pause;
   logic       s_abort;

   logic [6:0] cnt1, cnt2;
   logic       busy1, busy2, done1, done2;
   logic [7:0] per1;
   logic [1:0] per2;

   int n_checks = 0;
   int n_fail   = 0;

   multi_mode_counter u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (s_start),
      .cnt_val_i    (s_val),
      .mode_i       (s_mode),
      .dir_i        (s_dir),
      .prescale_i   (s_pre),
      .pause_i      (s_pause),
      .abort_i      (s_abort),
      .cnt_o        (cnt1),
      .busy_o       (busy1),
      .done_o       (done1),
      .period_cnt_o (per1)
   );

   multi_mode_counter #(
      .PERIOD_W (2)
   ) u_dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (s_start),
      .cnt_val_i    (s_val),
      .mode_i       (s_mode),
      .dir_i        (s_dir),
      .prescale_i   (s_pre),
      .pause_i      (s_pause),
      .abort_i      (s_abort),
      .cnt_o        (cnt2),
      .busy_o       (busy2),
      .done_o       (done2),
      .period_cnt_o (per2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: counts enabled edges since start and derives ticks,
   // position in period and completed periods by division.
   bit m_active, m_donecyc, m_done;
   int m_val, m_pre, m_n, m_periods, m_cnt;
   bit m_mode, m_dir;

   task automatic model_reset();
      m_active = 0; m_donecyc = 0; m_done = 0;
      m_val = 0; m_pre = 0; m_n = 0; m_periods = 0; m_cnt = 0;
      m_mode = 0; m_dir = 0;
   endtask

   task automatic model_step();
      int k, newp, pos;
      m_done = 0;
      if (m_donecyc) begin
         m_donecyc = 0;
      end else if (!m_active) begin
         if (s_start) begin
            m_val = int'(s_val); m_pre = int'(s_pre);
            m_mode = s_mode; m_dir = s_dir;
            m_active = 1; m_n = 0; m_periods = 0;
            m_cnt = s_dir ? m_val : 0;
         end
      end else if (s_abort) begin
         m_active = 0;
         m_cnt = 0;
      end else if (!s_pause) begin
         m_n++;
         if (m_n % (m_pre + 1) == 0) begin
            k    = m_n / (m_pre + 1);
            newp = k / (m_val + 1);
            pos  = k % (m_val + 1);
            if (newp != m_periods) begin
               m_done = 1;
               m_periods = newp;
            end
            if (m_done && !m_mode) begin
               m_active = 0; m_donecyc = 1;
               m_cnt = m_dir ? 0 : m_val;
            end else begin
               m_cnt = m_dir ? m_val - pos : pos;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("cnt", int'(cnt1), m_cnt);
      chk("busy", int'(busy1), int'(m_active || m_donecyc));
      chk("done", int'(done1), int'(m_done));
      chk("period", int'(per1), (m_periods > 255) ? 255 : m_periods);
      chk("period_sat", int'(per2), (m_periods > 3) ? 3 : m_periods);
      chk("cnt_sat_inst", int'(cnt2), m_cnt);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic set_in(input bit st, input int val, input bit mode, input bit dir,
                         input int pre, input bit pause, input bit abort);
      s_start = st; s_val = 7'(val); s_mode = mode; s_dir = dir;
      s_pre = 4'(pre); s_pause = pause; s_abort = abort;
   endtask

   // Asynchronous reset applied between clock edges.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_cnt", int'(cnt1), 0);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_period", int'(per1), 0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      bit st; int val; bit mode; bit dir; int pre; bit pause; bit abort;
      int e_cnt; bit e_busy; bit e_done; int e_per;
   } vec_t;

   function automatic vec_t mk(bit st, int val, bit mode, bit dir, int pre, bit pause,
                               bit abort, int e_cnt, bit e_busy, bit e_done, int e_per);
      vec_t v;
      v.st = st; v.val = val; v.mode = mode; v.dir = dir; v.pre = pre;
      v.pause = pause; v.abort = abort;
      v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_done = e_done; v.e_per = e_per;
      return v;
   endfunction

   vec_t vecs[10];

   initial begin
      int edge_done;
      int n_done;
      model_reset();
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #3;
      chk("reset_cnt", int'(cnt1), 0);
      chk("reset_busy", int'(busy1), 0);
      chk("reset_done", int'(done1), 0);
      chk("reset_period", int'(per1), 0);
      #1 rst_n = 1'b1;

      // Up one-shot val=3, abort in IDLE, val=0, start in DONE.
      vecs[0] = mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[1] = mk(0, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      vecs[2] = mk(0, 3, 0, 0, 0, 0, 0, 2, 1, 0, 0);
      vecs[3] = mk(0, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0);
      vecs[4] = mk(0, 3, 0, 0, 0, 0, 0, 3, 1, 1, 1);
      vecs[5] = mk(0, 3, 0, 0, 0, 0, 0, 3, 0, 0, 1);
      vecs[6] = mk(0, 3, 0, 0, 0, 0, 1, 3, 0, 0, 1);
      vecs[7] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      vecs[9] = mk(1, 5, 1, 1, 2, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         set_in(vecs[i].st, vecs[i].val, vecs[i].mode, vecs[i].dir, vecs[i].pre,
                vecs[i].pause, vecs[i].abort);
         cycle();
         chk($sformatf("vec%0d_cnt", i), int'(cnt1), vecs[i].e_cnt);
         chk($sformatf("vec%0d_busy", i), int'(busy1), int'(vecs[i].e_busy));
         chk($sformatf("vec%0d_done", i), int'(done1), int'(vecs[i].e_done));
         chk($sformatf("vec%0d_period", i), int'(per1), vecs[i].e_per);
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Down reload val=2, P=1: done every 6 edges.
      set_in(1, 2, 1, 1, 1, 0, 0);
      cycle();
      s_start = 0;
      n_done = 0;
      for (int e = 1; e <= 18; e++) begin
         cycle();
         chk("down_reload_done", int'(done1), int'(e % 6 == 0));
         if (done1) n_done++;
      end
      chk("down_reload_ndone", n_done, 3);
      chk("down_reload_period", int'(per1), 3);
      s_abort = 1; cycle(); s_abort = 0;

      // Pause for 3 sampled cycles at cnt=2 delays done from E6 to E9.
      set_in(1, 5, 0, 0, 0, 0, 0);
      cycle();
      s_start = 0;
      edge_done = -1;
      for (int e = 1; e <= 14; e++) begin
         s_pause = (e >= 3 && e <= 5);
         cycle();
         if (e >= 3 && e <= 5) chk("pause_hold", int'(cnt1), 2);
         if (done1 && edge_done < 0) edge_done = e;
      end
      s_pause = 0;
      chk("pause_done_edge", edge_done, 9);

      // Abort together with pause at cnt=4.
      set_in(1, 5, 1, 0, 0, 0, 0);
      cycle();
      s_start = 0;
      for (int e = 1; e <= 4; e++) cycle();
      s_abort = 1; s_pause = 1;
      cycle();
      s_abort = 0; s_pause = 0;
      chk("abort_pause_busy", int'(busy1), 0);
      chk("abort_pause_cnt", int'(cnt1), 0);

      // Abort exactly at the terminal tick suppresses done.
      set_in(1, 3, 0, 0, 0, 0, 0);
      cycle();
      s_start = 0;
      for (int e = 1; e <= 3; e++) cycle();
      s_abort = 1;
      cycle();
      s_abort = 0;
      chk("abort_term_done", int'(done1), 0);
      chk("abort_term_busy", int'(busy1), 0);
      cycle();
      chk("abort_term_done_late", int'(done1), 0);

      // Start and config changes during RUN are ignored.
      set_in(1, 4, 1, 0, 0, 0, 0);
      cycle();
      set_in(1, 1, 0, 1, 3, 0, 0);
      cycle(); cycle();
      chk("start_in_run_cnt", int'(cnt1), 2);
      s_start = 0;
      for (int e = 1; e <= 12; e++) cycle();
      s_abort = 1; cycle(); s_abort = 0;

      // Saturation: val=127 reload for five full periods.
      set_in(1, 127, 1, 0, 0, 0, 0);
      cycle();
      s_start = 0;
      for (int e = 1; e <= 640; e++) cycle();
      chk("sat_period_w2", int'(per2), 3);
      chk("sat_period_w8", int'(per1), 5);
      s_abort = 1; cycle(); s_abort = 0;

      // Asynchronous reset mid-run, then a fresh run.
      set_in(1, 10, 1, 0, 2, 0, 0);
      cycle();
      s_start = 0;
      for (int e = 1; e <= 5; e++) cycle();
      do_reset();
      set_in(1, 2, 0, 0, 0, 0, 0);
      cycle();
      s_start = 0;
      cycle(); cycle(); cycle();
      chk("post_reset_done", int'(done1), 1);
      chk("post_reset_cnt", int'(cnt1), 2);
      cycle();

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 4) == 0, int'($urandom_range(0, 12)), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_mode_counter.md
Name: multi_mode_counter

Overview:
Parametrised successor to the team's start/run/done counter-with-FSM block. Adds up/down direction, one-shot and auto-reload modes, a programmable clock-enable prescaler, pause, abort and a completed-period count. Sits next to control FSMs that need programmable delays or periodic ticks, with one instance per timed function.

Parameters:
CNT_WIDTH, 7, width of the count value and terminal value
PRE_WIDTH, 4, width of the prescaler divide value
PERIOD_W, 8, width of the saturating completed-period counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start request; sampled only in IDLE
cnt_val_i  in  CNT_WIDTH  terminal value (up) or start value (down); latched on start
mode_i  in  1  0 = one-shot, 1 = auto-reload; latched on start
dir_i  in  1  0 = up, 1 = down; latched on start
prescale_i  in  PRE_WIDTH  tick every prescale_i+1 cycles; latched on start
pause_i  in  1  level; freezes counting while high
abort_i  in  1  pulse or level; cancels the run
cnt_o  out  CNT_WIDTH  current count
busy_o  out  1  high when state != IDLE
done_o  out  1  one-cycle pulse per completed period
period_cnt_o  out  PERIOD_W  completed periods since start, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cnt_o, period_cnt_o, prescaler count and latched config all 0; busy_o=0; done_o=0.
- States: IDLE, RUN, PAUSE, DONE. The state register is the single source of busy_o.
- IDLE to RUN: start_i=1 at edge E0.
  - Latch val, mode, dir and prescale.
  - cnt = 0 (up) or val (down).
  - Prescaler count = 0; period_cnt cleared.
- Tick: in RUN, an edge where prescaler count == latched prescale. At a tick the prescaler count returns to 0; otherwise it increments. Tick k occurs at edge E(k*(P+1)).
- At a non-terminal tick: cnt +1 (up) or -1 (down). No arithmetic wrap is possible.
- Terminal tick: the tick where cnt == val (up) or cnt == 0 (down). This is tick val+1, so it falls at edge E((val+1)*(P+1)).
  - One-shot: go to DONE; cnt holds the terminal value; done_o=1 for exactly the DONE cycle; next edge goes to IDLE. cnt_o holds until the next start.
  - Reload: stay in RUN; cnt reloads to its start value; done_o=1 for one cycle after that edge.
  - Both modes: period_cnt +1, saturating at 2^PERIOD_W-1.
- cnt_val_i=0: the first tick is terminal, so done_o follows edge E(P+1).
- RUN to PAUSE: pause_i=1 at an edge. cnt and the prescaler count freeze; the tick at that edge is suppressed. PAUSE to RUN when pause_i=0; counting resumes from the frozen values.
- Abort: abort_i=1 in RUN or PAUSE goes to IDLE next edge, with cnt=0, no done_o and period_cnt held.
  - Priority: abort > pause > terminal tick.
  - Abort in IDLE or DONE: no effect.
- start_i outside IDLE is ignored, including DONE. Config input changes during a run are ignored.
- done_o and busy_o are registered (driven from state/flops, no combinational paths from inputs).
- Reset mid-run: immediate return to reset values; no done_o.

Decomposition:
- Shared package counter_pkg holds:
  - state enum (IDLE/RUN/PAUSE/DONE)
  - mode constants MODE_ONESHOT=0, MODE_RELOAD=1
  - direction constants DIR_UP=0, DIR_DOWN=1
- One sub-module, counter_prescaler:
  - ports: clk, rst_n, clear, en, div value
  - output: tick pulse
- The top holds the FSM, the count register and the period counter.

Test Plan:
- Up one-shot: val=3, P=0, start at E0 -> cnt 0,1,2,3 after E0..E3; done_o high after E4 only; busy_o low after E5; cnt_o stays 3.
- Down reload: val=2, P=1 -> cnt 2,2,1,1,0,0 then reload to 2; done_o pulses every 6 cycles; period_cnt 1,2,3.
- Pause: up, val=5, P=0, pause_i high 3 cycles at cnt=2 -> cnt holds 2 for those cycles; done_o delayed by exactly 3 cycles.
- Abort priority: abort_i and pause_i together at cnt=4 -> IDLE next cycle, cnt=0, no done_o.
  - Repeat with abort_i at the terminal tick -> no done_o.
- Edge values: val=0, P=0 -> done_o after E1.
  - val=127, PERIOD_W=2 reload -> period_cnt saturates at 3.
  - start_i during RUN/DONE ignored.
- Async reset: assert rst_n=0 mid-RUN between edges -> all outputs 0 immediately; a start after release behaves as a fresh run.
